// File: rtl/uart_alu_interface.sv
// ---------------------------------------------------------------------------
// uart_alu_interface
//
// Purpose:
//    Collects three bytes from a UART receiver: operand A, operand B and an
//    opcode. The operands and opcode are presented to an external
//    combinational ALU. The ALU result is captured and handed to a UART
//    transmitter. The block then waits for the transmitter to finish before
//    it accepts the next frame.
//
// Optional feature:
//    Define the macro INTF_TIMEOUT_EN to build an inter-byte timeout. When the
//    macro is undefined, no counter is built and o_timeout is tied to 0.
//
// Ports:
//    i_clk         in   1               clock, rising edge
//    i_reset       in   1               asynchronous active-high reset
//    i_rx_done     in   1               one-cycle pulse: i_rx_data is valid
//    i_rx_data     in   SIZE_TRAMA_BIT  received byte
//    i_alu_result  in   SIZE_TRAMA_BIT  combinational ALU result
//    i_tx_done     in   1               one-cycle pulse: transmit finished
//    o_alu_a       out  SIZE_TRAMA_BIT  registered operand A
//    o_alu_b       out  SIZE_TRAMA_BIT  registered operand B
//    o_alu_op      out  SIZE_OP         registered opcode
//    o_tx_data     out  SIZE_TRAMA_BIT  registered result byte
//    o_tx_start    out  1               one-cycle transmit request
//    o_busy        out  1               a result is in flight
//    o_overrun     out  1               sticky: a byte arrived while busy
//    o_timeout     out  1               one-cycle pulse: frame abandoned
// ---------------------------------------------------------------------------
module uart_alu_interface #(
   parameter int SIZE_TRAMA_BIT = 8,
   parameter int SIZE_OP        = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_rx_done,
   input  logic [SIZE_TRAMA_BIT-1:0] i_rx_data,
   input  logic [SIZE_TRAMA_BIT-1:0] i_alu_result,
   input  logic                      i_tx_done,
   output logic [SIZE_TRAMA_BIT-1:0] o_alu_a,
   output logic [SIZE_TRAMA_BIT-1:0] o_alu_b,
   output logic [SIZE_OP-1:0]        o_alu_op,
   output logic [SIZE_TRAMA_BIT-1:0] o_tx_data,
   output logic                      o_tx_start,
   output logic                      o_busy,
   output logic                      o_overrun,
   output logic                      o_timeout
);

   // One-hot state bit positions
   localparam int ST_WAIT_A  = 0;
   localparam int ST_WAIT_B  = 1;
   localparam int ST_WAIT_OP = 2;
   localparam int ST_RESULT  = 3;
   localparam int ST_SEND    = 4;
   localparam int ST_WAIT_TX = 5;

   logic [5:0]                r_state;
   logic [5:0]                w_state_next;
   logic [SIZE_TRAMA_BIT-1:0] r_alu_a;
   logic [SIZE_TRAMA_BIT-1:0] r_alu_b;
   logic [SIZE_OP-1:0]        r_alu_op;
   logic [SIZE_TRAMA_BIT-1:0] r_tx_data;
   logic                      r_overrun;
   logic                      w_busy;
   logic                      w_expire;

   // ------------------------------------------------------------------------
   // Inter-byte timeout
   // ------------------------------------------------------------------------
`ifdef INTF_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;
   logic             w_waiting;

   assign w_waiting = r_state[ST_WAIT_B] | r_state[ST_WAIT_OP];

   // A byte arriving in the expiry cycle is accepted, so it suppresses expiry.
   assign w_expire = w_waiting && !i_rx_done &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (w_waiting && !i_rx_done && !w_expire) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_timeout = r_timeout;
`else
   assign w_expire  = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= 6'b000001;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = '0;
      case (1'b1)
         r_state[ST_WAIT_A]: begin
            if (i_rx_done) w_state_next[ST_WAIT_B] = 1'b1;
            else           w_state_next[ST_WAIT_A] = 1'b1;
         end
         r_state[ST_WAIT_B]: begin
            if (i_rx_done)     w_state_next[ST_WAIT_OP] = 1'b1;
            else if (w_expire) w_state_next[ST_WAIT_A]  = 1'b1;
            else               w_state_next[ST_WAIT_B]  = 1'b1;
         end
         r_state[ST_WAIT_OP]: begin
            if (i_rx_done)     w_state_next[ST_RESULT]  = 1'b1;
            else if (w_expire) w_state_next[ST_WAIT_A]  = 1'b1;
            else               w_state_next[ST_WAIT_OP] = 1'b1;
         end
         r_state[ST_RESULT]: w_state_next[ST_SEND]    = 1'b1;
         r_state[ST_SEND]:   w_state_next[ST_WAIT_TX] = 1'b1;
         r_state[ST_WAIT_TX]: begin
            if (i_tx_done) w_state_next[ST_WAIT_A]  = 1'b1;
            else           w_state_next[ST_WAIT_TX] = 1'b1;
         end
         // Any corrupted encoding recovers to the idle state.
         default: w_state_next[ST_WAIT_A] = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------------
   always_comb begin
      o_tx_start = r_state[ST_SEND];
      w_busy     = r_state[ST_RESULT] | r_state[ST_SEND] | r_state[ST_WAIT_TX];
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_op  <= '0;
         r_tx_data <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (r_state[ST_WAIT_A] && i_rx_done) begin
            r_alu_a   <= i_rx_data;
            r_overrun <= 1'b0;
         end
         if (r_state[ST_WAIT_B] && i_rx_done) begin
            r_alu_b <= i_rx_data;
         end
         if (r_state[ST_WAIT_OP] && i_rx_done) begin
            r_alu_op <= i_rx_data[SIZE_OP-1:0];
         end
         // Operands settled one cycle ago, so the ALU output is stable here.
         if (r_state[ST_RESULT]) begin
            r_tx_data <= i_alu_result;
         end
         // Bytes arriving while a result is in flight are dropped.
         if (w_busy && i_rx_done) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign o_alu_a   = r_alu_a;
   assign o_alu_b   = r_alu_b;
   assign o_alu_op  = r_alu_op;
   assign o_tx_data = r_tx_data;
   assign o_busy    = w_busy;
   assign o_overrun = r_overrun;

   // Opcode bits above SIZE_OP and, without the timeout, TIMEOUT_CYCLES are
   // intentionally unused.
   logic w_unused;
   assign w_unused = ^i_rx_data | (TIMEOUT_CYCLES == 0);

endmodule
